// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : counter_seq_pkg
// Brief    : Command opcodes and sequencer states for counter_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
package counter_seq_pkg;

    typedef enum logic [1:0] {
        OP_START  = 2'd0,
        OP_STOP   = 2'd1,
        OP_RESUME = 2'd2,
        OP_CLEAR  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
// Module   : counter_core
// Brief    : Up-counter with synchronous clear (priority) and count enable.
// Revision : 1.0 - initial release
// ============================================================================
module counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_seq_ctrl
// Brief    : Command-driven sequencer (FSM, prescaler, config, event pulses)
//            wrapped around a counter_core instance.
// Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [WIDTH-1:0]   cmd_limit,
    input  logic [PRESC_W-1:0] cmd_presc,
    input  logic               cmd_reload,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic               wrap,
    output logic               err
);

    state_e               r_state;
    logic [PRESC_W-1:0]   r_presc_cnt;
    logic [PRESC_W-1:0]   r_presc;
    logic [WIDTH-1:0]     r_limit;
    logic                 r_reload;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_wrap;
    logic                 r_err;

    cmd_op_e              w_op;
    logic                 w_accept;
    logic                 w_tick;
    logic                 w_term;
    logic                 w_start;
    logic                 w_clear;
    logic                 w_clr;
    logic                 w_en;

    assign w_op     = cmd_op_e'(cmd_op);
    assign w_accept = cmd_valid && r_ready;

    // Any accepted command owns its cycle: the prescaler and count stand still,
    // which also gives commands priority over a coincident terminal tick.
    assign w_tick   = (r_state == S_RUN) && !w_accept && (r_presc_cnt == r_presc);
    assign w_term   = w_tick && (count == r_limit);
    assign w_start  = w_accept && (w_op == OP_START) &&
                      ((r_state == S_IDLE) || (r_state == S_PAUSED));
    assign w_clear  = w_accept && (w_op == OP_CLEAR);
    assign w_clr    = w_start || w_clear || (w_term && r_reload);
    assign w_en     = w_tick && !w_term;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_presc_cnt <= '0;
            r_presc     <= '0;
            r_limit     <= '0;
            r_reload    <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_wrap      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                S_IDLE, S_PAUSED: begin
                    if (w_accept) begin
                        unique case (w_op)
                            OP_START: begin
                                r_state     <= S_RUN;
                                r_busy      <= 1'b1;
                                r_presc_cnt <= '0;
                                r_limit     <= cmd_limit;
                                r_presc     <= cmd_presc;
                                r_reload    <= cmd_reload;
                            end
                            OP_CLEAR: begin
                                r_state     <= S_IDLE;
                                r_busy      <= 1'b0;
                                r_presc_cnt <= '0;
                            end
                            OP_RESUME: begin
                                if (r_state == S_PAUSED) begin
                                    r_state <= S_RUN;
                                end else begin
                                    r_err   <= 1'b1;
                                end
                            end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        unique case (w_op)
                            OP_STOP:  r_state <= S_PAUSED;
                            OP_CLEAR: begin
                                r_state     <= S_IDLE;
                                r_busy      <= 1'b0;
                                r_presc_cnt <= '0;
                            end
                            default:  r_err <= 1'b1;
                        endcase
                    end else if (w_tick) begin
                        r_presc_cnt <= '0;
                        if (w_term) begin
                            if (r_reload) begin
                                r_wrap  <= 1'b1;
                            end else begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end
                    end else begin
                        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign wrap      = r_wrap;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_seq_ctrl
// Brief    : Directed and random stimulus against a behavioural sequencer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    localparam int WIDTH   = 4;
    localparam int PRESC_W = 8;

    localparam int T_START  = 0;
    localparam int T_STOP   = 1;
    localparam int T_RESUME = 2;
    localparam int T_CLEAR  = 3;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_DONE   = 3;

    logic               clk        = 1'b0;
    logic               rst        = 1'b0;
    logic               cmd_valid  = 1'b0;
    logic [1:0]         cmd_op     = '0;
    logic [WIDTH-1:0]   cmd_limit  = '0;
    logic [PRESC_W-1:0] cmd_presc  = '0;
    logic               cmd_reload = 1'b0;
    logic               cmd_ready;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               done;
    logic               wrap;
    logic               err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode, visible count, and cycles remaining until next step.
    int m_mode, m_cnt, m_lim, m_presc, m_wait;
    bit m_reload, m_ready, m_done, m_wrap, m_err;

    counter_seq_ctrl #(
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_limit  (cmd_limit),
        .cmd_presc  (cmd_presc),
        .cmd_reload (cmd_reload),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0; m_lim = 0; m_presc = 0; m_wait = 1;
        m_reload = 0; m_ready = 0; m_done = 0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_edge(input bit valid, input int op, input int lim,
                              input int presc, input bit reload);
        bit acc;
        acc = valid && m_ready;
        m_done = 0; m_wrap = 0; m_err = 0;
        if (m_mode == M_DONE) begin
            m_mode = M_IDLE;
        end else if (acc) begin
            case (op)
                T_START: begin
                    if (m_mode == M_RUN) m_err = 1;
                    else begin
                        m_mode = M_RUN; m_cnt = 0; m_lim = lim; m_presc = presc;
                        m_reload = reload; m_wait = presc + 1;
                    end
                end
                T_STOP:   if (m_mode == M_RUN) m_mode = M_PAUSED; else m_err = 1;
                T_RESUME: if (m_mode == M_PAUSED) m_mode = M_RUN; else m_err = 1;
                default:  begin m_mode = M_IDLE; m_cnt = 0; end
            endcase
        end else if (m_mode == M_RUN) begin
            m_wait--;
            if (m_wait == 0) begin
                m_wait = m_presc + 1;
                if (m_cnt < m_lim) m_cnt++;
                else if (m_reload) begin m_cnt = 0; m_wrap = 1; end
                else begin m_mode = M_DONE; m_done = 1; end
            end
        end
        m_ready = (m_mode != M_DONE);
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".count"}, 32'(count),     32'(m_cnt));
        check_eq({tag, ".busy"},  32'(busy),      32'((m_mode == M_RUN) || (m_mode == M_PAUSED)));
        check_eq({tag, ".ready"}, 32'(cmd_ready), 32'(m_ready));
        check_eq({tag, ".done"},  32'(done),      32'(m_done));
        check_eq({tag, ".wrap"},  32'(wrap),      32'(m_wrap));
        check_eq({tag, ".err"},   32'(err),       32'(m_err));
    endtask

    task automatic cycle(input string tag, input bit valid, input int op,
                         input int lim, input int presc, input bit reload);
        cmd_valid  = valid;
        cmd_op     = 2'(op);
        cmd_limit  = WIDTH'(lim);
        cmd_presc  = PRESC_W'(presc);
        cmd_reload = reload;
        @(posedge clk);
        model_edge(valid, op, lim, presc, reload);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, T_START, 0, 0, 1'b0);
    endtask

    initial begin
        bit v, rl;
        int op, lim, pr;

        // Power-on reset, then a START presented on the first edge is not taken.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("por.ready", 32'(cmd_ready), 32'd0);
        check_eq("por.count", 32'(count),     32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle("por.first", 1'b1, T_START, 3, 0, 1'b0);
        idle("por.idle", 1);

        cycle("oneshot.start", 1'b1, T_START, 3, 0, 1'b0);
        idle("oneshot", 7);

        cycle("reload.start", 1'b1, T_START, 2, 1, 1'b1);
        idle("reload", 14);
        cycle("reload.clear", 1'b1, T_CLEAR, 0, 0, 1'b0);

        cycle("pause.start", 1'b1, T_START, 4, 0, 1'b0);
        idle("pause.run", 2);
        cycle("pause.stop", 1'b1, T_STOP, 0, 0, 1'b0);
        idle("pause.frozen", 10);
        cycle("pause.resume", 1'b1, T_RESUME, 0, 0, 1'b0);
        idle("pause.tail", 6);

        cycle("ill.resume_idle", 1'b1, T_RESUME, 0, 0, 1'b0);
        cycle("ill.stop_idle", 1'b1, T_STOP, 0, 0, 1'b0);
        cycle("ill.start", 1'b1, T_START, 5, 2, 1'b0);
        idle("ill.run", 3);
        cycle("ill.start_run", 1'b1, T_START, 9, 0, 1'b1);
        cycle("ill.stop", 1'b1, T_STOP, 0, 0, 1'b0);
        cycle("ill.stop_paused", 1'b1, T_STOP, 0, 0, 1'b0);
        cycle("ill.clear", 1'b1, T_CLEAR, 0, 0, 1'b0);

        cycle("coll.start", 1'b1, T_START, 1, 0, 1'b0);
        idle("coll.run", 1);
        cycle("coll.stop", 1'b1, T_STOP, 0, 0, 1'b0);
        idle("coll.paused", 2);
        cycle("coll.clear", 1'b1, T_CLEAR, 0, 0, 1'b0);

        cycle("zero.start", 1'b1, T_START, 0, 0, 1'b1);
        idle("zero.wrap", 4);
        cycle("zero.clear", 1'b1, T_CLEAR, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a run.
        cycle("rst.start", 1'b1, T_START, 9, 0, 1'b0);
        idle("rst.run", 5);
        #2 rst = 1'b0;
        #1;
        check_eq("rst.async.count", 32'(count),     32'd0);
        check_eq("rst.async.busy",  32'(busy),      32'd0);
        check_eq("rst.async.ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst.held.ready", 32'(cmd_ready), 32'd0);
        check_eq("rst.held.done",  32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_eq("rst.rel.ready", 32'(cmd_ready), 32'd0);
        cycle("rst.after", 1'b1, T_STOP, 0, 0, 1'b0);
        idle("rst.after", 2);

        for (int i = 0; i < 600; i++) begin
            v   = ($urandom_range(0, 3) == 0);
            op  = ($urandom_range(0, 2) == 0) ? T_START : int'($urandom_range(0, 3));
            lim = $urandom_range(0, 15);
            pr  = $urandom_range(0, 3);
            rl  = 1'($urandom_range(0, 1));
            cycle("rand", v, op, lim, pr, rl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
